// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's two handshakes.
//   imem_*     : request/grant channel out to instruction memory, plus the
//                in-order read-response channel coming back.
//   redirect_* : control-flow redirect pulse and its target.
//   id_*       : {instr, pc} valid/ready channel into decode.
// modport master = fetch stage side, modport slave = memory/decode side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the PC, issues word fetches, tags each grant with its PC, and buffers
// in-order responses in a FIFO_DEPTH-entry queue feeding decode.
// Redirects flush the buffer and drop responses to requests already in flight.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (imem req/gnt/rvalid, redirect, id valid/ready)
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;      // granted requests whose response is still due
  logic [CW-1:0] r_discard;  // how many of those belong to a dead path
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_tag        [FIFO_DEPTH];
  logic [PW-1:0] r_tag_wptr, r_tag_rptr;

  logic [CW:0]   w_inflight;
  logic          w_req, w_grant, w_rvalid, w_drop, w_push, w_pop, w_valid;
  logic [CW-1:0] w_out_nxt;

  // Credits: buffered words plus in-flight requests never exceed the FIFO,
  // so any response that survives the discard check always has a slot.
  assign w_inflight = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_req      = (r_state != S_BOOT) && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_grant    = w_req && bus.imem_gnt_i;
  assign w_rvalid   = bus.imem_rvalid_i;
  // A word landing in the redirect cycle is from the old path as well.
  assign w_drop     = w_rvalid && ((r_discard != '0) || bus.redirect_i);
  assign w_push     = w_rvalid && !w_drop;
  assign w_valid    = (r_cnt != '0);
  assign w_pop      = w_valid && bus.id_ready_i;
  assign w_out_nxt  = r_out + CW'(w_grant) - CW'(w_rvalid);

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_pc;
  assign bus.id_valid_o  = w_valid;
  assign bus.id_instr_o  = w_valid ? r_fifo_instr[r_rptr] : '0;
  assign bus.id_pc_o     = w_valid ? r_fifo_pc[r_rptr]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_VECTOR;
      r_out     <= '0;
      r_discard <= '0;
    end else begin
      r_out <= w_out_nxt;

      // Redirect wins over the increment: a grant this cycle was for the
      // old path and is accounted for in the new discard count.
      if (bus.redirect_i)
        r_pc <= bus.redirect_pc_i & ~32'h3;
      else if (w_grant)
        r_pc <= r_pc + 32'd4;

      // Everything still outstanding after this cycle is stale.
      if (bus.redirect_i)
        r_discard <= w_out_nxt;
      else if (w_rvalid && (r_discard != '0))
        r_discard <= r_discard - CW'(1);

      case (r_state)
        S_BOOT:    r_state <= S_RUN;
        S_RUN:     if (bus.redirect_i && (w_out_nxt != '0)) r_state <= S_DISCARD;
        S_DISCARD: if (!bus.redirect_i && (r_discard == '0)) r_state <= S_RUN;
        default:   r_state <= S_BOOT;
      endcase
    end
  end

  // PC tag queue: pushed on grant, popped on every response (kept or dropped),
  // so it stays aligned with the memory's in-order returns across redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_tag[i] <= '0;
    end else begin
      if (w_grant) begin
        r_tag[r_tag_wptr] <= r_pc;
        r_tag_wptr        <= r_tag_wptr + PW'(1);
      end
      if (w_rvalid) r_tag_rptr <= r_tag_rptr + PW'(1);
    end
  end

  // Instruction buffer. Flush on redirect takes priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (bus.redirect_i) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wptr] <= bus.imem_rdata_i;
        r_fifo_pc[r_wptr]    <= r_tag[r_tag_rptr];
        r_wptr               <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // More stale responses than outstanding ones would mean a lost response.
  a_discard_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    r_discard <= r_out);

endmodule
